and2_fault_responder: RTL
=========================

# and2_fault_responder

Synthesizable device-side responder for the two-input AND stuck-at fault experiments: it accepts test vectors from a tester over a valid/ready handshake, applies a programmable stuck-at fault set to inputs A, B and output Z, and returns the faulty response alongside the fault-free expectation. It replaces `force`-based fault injection with a register-programmed fault model, so the same stuck-at diagnosis runs in hardware against a pipelined, back-pressured interface.

## Interface
- `LATENCY`, 2, pipeline stages from vector accept to response valid; legal 1..4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, synchronous and active-high.
- `cfg_we`  in  1  fault-config write strobe.
- `cfg_data`  in  6  fault codes: [1:0] A, [3:2] B, [5:4] Z; 00 none, 01 sa0, 10 sa1, 11 reserved (treated as none).
- `cfg_rejected`  out  1  one-cycle pulse: the write was refused because the block was busy.
- `fault_cfg`  out  6  current fault configuration (readback).
- `vec_valid`  in  1  tester presents a vector.
- `vec_ready`  out  1  responder can accept a vector.
- `vec_a`, `vec_b`  in  1 each  ideal input values.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  tester accepts the response.
- `rsp_a`, `rsp_b`  out  1 each  effective (post-fault) inputs.
- `rsp_z`  out  1  faulty output.
- `rsp_ideal_z`  out  1  vec_a & vec_b.
- `rsp_mismatch`  out  1  rsp_z != rsp_ideal_z.
- `busy`  out  1  at least one vector is in flight or held at the output.
- `vec_count`  out  8  vectors accepted, saturating at 255.
- `mismatch_count`  out  8  responses delivered with a mismatch, saturating at 255.

## Operation
- Fault application:
  - eff_a = vec_a forced by the A code; eff_b = vec_b forced by the B code.
  - z_raw = eff_a & eff_b; rsp_z = z_raw forced by the Z code.
  - sa0 forces 0; sa1 forces 1; none or reserved passes the value through.
- Configuration snapshot: the configuration is captured with each vector at accept, so every response reflects the configuration in force when its vector was accepted.
- Configuration writes:
  - Accepted only when busy=0 and no vector is being accepted in the same cycle (`vec_valid & vec_ready` = 0).
  - A refused write leaves `fault_cfg` unchanged and pulses `cfg_rejected` for one cycle.
  - An accepted write updates `fault_cfg` the next cycle.
- Pipeline:
  - LATENCY registered stages, each with a valid bit; the last stage drives the `rsp_*` outputs.
  - A stall occurs when rsp_valid=1 and rsp_ready=0; during a stall every stage holds.
  - vec_ready = !stall.
- Handshakes: a vector transfers on `vec_valid & vec_ready`; a response transfers on `rsp_valid & rsp_ready`. `rsp_*` outputs stay stable while rsp_valid=1 and rsp_ready=0.
- Counters:
  - `vec_count` increments on each vector transfer.
  - `mismatch_count` increments on each response transfer with rsp_mismatch=1.
  - Both saturate at 255 and never wrap.
- busy is the OR of all stage valid bits.

## Timing
- Reset (synchronous, on the clock edge with rst=1):
  - fault_cfg=0, all stage valids=0, rsp_valid=0.
  - rsp_a/rsp_b/rsp_z/rsp_ideal_z/rsp_mismatch=0.
  - vec_count=0, mismatch_count=0, cfg_rejected=0, busy=0.
  - vec_ready=1 from the first cycle after reset.
- Reset mid-operation: in-flight vectors are discarded with no response and counters clear; vec_ready is high in the reset cycle's aftermath but nothing is accepted while rst=1.
- Latency: a vector accepted at edge t gives rsp_valid=1 after edge t+LATENCY-1 (LATENCY cycles) when there is no stall.
- Throughput: one vector per cycle with rsp_ready held high.
- Simultaneous events:
  - Response transfer and vector accept in the same cycle: both occur, with no bubble.
  - cfg_we in the same cycle as a vector accept: the write is refused.
  - cfg_we in the first cycle busy=0 after the last response transfer: the write is accepted.
- `cfg_rejected` and the counters are registered and update one cycle after the triggering edge.

## Test plan
- No fault, LATENCY=2, rsp_ready=1:
  - Stimulus: vectors (0,0),(0,1),(1,0),(1,1) on consecutive cycles.
  - Required: responses 2 cycles later with rsp_z=0,0,0,1; mismatch all 0; vec_count=4, mismatch_count=0.
- cfg B sa1 (cfg_data=6'b001000), same four vectors:
  - Required: rsp_b=1 on every response; rsp_z=0,0,1,1.
  - Required: mismatch only on (1,0); mismatch_count=1.
- cfg Z sa0 (cfg_data=6'b010000):
  - Stimulus: (1,1).
  - Required: rsp_z=0, rsp_ideal_z=1, mismatch=1.
  - Stimulus: (0,0).
  - Required: mismatch=0.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles while vectors are offered.
  - Required: vec_ready drops once the first response is held; rsp_* stays stable; no vector is lost or duplicated after release; order is preserved.
- Configuration timing:
  - Stimulus: cfg_we while busy=1.
  - Required: cfg_rejected pulses and fault_cfg is unchanged.
  - Stimulus: vector V1 is accepted, the pipeline then drains, and the configuration is rewritten before V2.
  - Required: V1's response uses the old configuration and V2's uses the new one.
- Saturation and reset:
  - Stimulus: 300 vectors with A sa1 and a (0,1) pattern.
  - Required: vec_count=255 and mismatch_count=255, held.
  - Stimulus: assert rst with 2 vectors in flight.
  - Required: no rsp_valid after reset; counters=0; fault_cfg=0.

Source files
------------

// File: rtl/and2_fault_responder.sv
// and2_fault_responder: device-side responder for two-input AND stuck-at experiments.
// Vectors enter over valid/ready. The programmed stuck-at faults on A, B and Z are
// applied at accept, and the faulty and fault-free results travel down a LATENCY-deep
// pipeline to the response port.
module and2_fault_responder #(
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [5:0] cfg_data,
    output logic       cfg_rejected,
    output logic [5:0] fault_cfg,
    input  logic       vec_valid,
    output logic       vec_ready,
    input  logic       vec_a,
    input  logic       vec_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_a,
    output logic       rsp_b,
    output logic       rsp_z,
    output logic       rsp_ideal_z,
    output logic       rsp_mismatch,
    output logic       busy,
    output logic [7:0] vec_count,
    output logic [7:0] mismatch_count
);

    // Handshake rules: a vector transfers on a rising edge where vec_valid & vec_ready,
    // a response transfers on a rising edge where rsp_valid & rsp_ready; while valid is
    // high and the transfer has not happened, the payload on that side stays stable.

    typedef struct packed {
        logic valid;
        logic a;
        logic b;
        logic z;
        logic ideal;
    } stage_t;

    stage_t             r_stage [LATENCY];
    logic [5:0]         r_fault_cfg;
    logic               r_cfg_rejected;
    logic [7:0]         r_vec_count;
    logic [7:0]         r_mismatch_count;

    logic [LATENCY-1:0] w_valid_vec;
    stage_t             w_last;
    stage_t             w_new;
    logic               w_stall;
    logic               w_vec_fire;
    logic               w_rsp_fire;
    logic               w_busy;
    logic               w_cfg_ok;
    logic               w_eff_a;
    logic               w_eff_b;
    logic               w_z;

    // 01 forces 0, 10 forces 1, 00 and the reserved 11 pass the value through.
    function automatic logic apply_fault(input logic value, input logic [1:0] code);
        case (code)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return value;
        endcase
    endfunction

    assign w_last     = r_stage[LATENCY-1];
    assign w_stall    = w_last.valid & ~rsp_ready;
    assign w_vec_fire = vec_valid & ~w_stall;
    assign w_rsp_fire = w_last.valid & rsp_ready;
    assign w_busy     = |w_valid_vec;
    // A write may only land when nothing is in flight and no vector enters this cycle,
    // so a configuration can never change underneath an accepted vector.
    assign w_cfg_ok   = cfg_we & ~w_busy & ~w_vec_fire;

    // Faults are applied at accept time, which snapshots the configuration per vector.
    assign w_eff_a = apply_fault(vec_a, r_fault_cfg[1:0]);
    assign w_eff_b = apply_fault(vec_b, r_fault_cfg[3:2]);
    assign w_z     = apply_fault(w_eff_a & w_eff_b, r_fault_cfg[5:4]);

    // Build the head-stage payload; an empty slot carries all zeros.
    always_comb begin
        w_new = '0;
        if (vec_valid) begin
            w_new.valid = 1'b1;
            w_new.a     = w_eff_a;
            w_new.b     = w_eff_b;
            w_new.z     = w_z;
            w_new.ideal = vec_a & vec_b;
        end
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        assign w_valid_vec[g] = r_stage[g].valid;
        if (g == 0) begin : g_head
            // Head stage: capture the incoming vector unless the pipeline is stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stage[0] <= '0;
                end else if (!w_stall) begin
                    r_stage[0] <= w_new;
                end
            end
        end else begin : g_body
            // Body stage: advance from the previous stage; every stage holds on a stall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stage[g] <= '0;
                end else if (!w_stall) begin
                    r_stage[g] <= r_stage[g-1];
                end
            end
        end
    end

    // Configuration register, refusal pulse and saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_cfg      <= '0;
            r_cfg_rejected   <= 1'b0;
            r_vec_count      <= '0;
            r_mismatch_count <= '0;
        end else begin
            r_cfg_rejected <= cfg_we & ~w_cfg_ok;
            if (w_cfg_ok) begin
                r_fault_cfg <= cfg_data;
            end
            if (w_vec_fire && (r_vec_count != 8'hFF)) begin
                r_vec_count <= r_vec_count + 8'd1;
            end
            if (w_rsp_fire && (w_last.z != w_last.ideal) && (r_mismatch_count != 8'hFF)) begin
                r_mismatch_count <= r_mismatch_count + 8'd1;
            end
        end
    end

    assign vec_ready      = ~w_stall;
    assign rsp_valid      = w_last.valid;
    assign rsp_a          = w_last.a;
    assign rsp_b          = w_last.b;
    assign rsp_z          = w_last.z;
    assign rsp_ideal_z    = w_last.ideal;
    assign rsp_mismatch   = w_last.z ^ w_last.ideal;
    assign busy           = w_busy;
    assign fault_cfg      = r_fault_cfg;
    assign cfg_rejected   = r_cfg_rejected;
    assign vec_count      = r_vec_count;
    assign mismatch_count = r_mismatch_count;

endmodule
